// File: rtl/sitcpxg_pkg.sv
// Shared types and helpers for the SiTCP-XG receive-side stream buffer.
package sitcpxg_pkg;

  localparam int unsigned SITCP_RX_MARGIN = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FETCH,
    ST_PRESENT,
    ST_CLEAR
  } rx_state_e;

  function automatic bit legal_width(input int unsigned addr_w, input int unsigned out_bytes);
    return (addr_w >= 12) && (addr_w <= 16) &&
           ((out_bytes == 1) || (out_bytes == 2) || (out_bytes == 4) || (out_bytes == 8));
  endfunction

  // Trailing-zero count; an all-zero input returns 8.
  function automatic logic [3:0] tz8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd8;
    for (int unsigned i = 0; i < 8; i++)
      if (v[7-i]) n = 4'(7 - i);
    return n;
  endfunction

endpackage

// File: rtl/sitcpxg_lane_ram.sv
// One byte lane of the receive buffer: simple dual-port RAM with registered read.
module sitcpxg_lane_ram #(
  parameter int unsigned DEPTH_W = 13
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic               re,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sitcpxg_rx_stream_buffer.sv
// SiTCP-XG receive buffer: captures the core's big-endian byte-lane write port
// and presents the stored TCP stream as a valid/ready word stream.
module sitcpxg_rx_stream_buffer
  import sitcpxg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned OUT_BYTES    = 8,
  parameter int unsigned TAIL_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [15:0]            SITCP_RX_WADR,
  input  logic [7:0]             SITCP_RX_WENB,
  input  logic [63:0]            SITCP_RX_WDAT,
  output logic [15:0]            SITCP_RX_RADR,
  output logic [15:0]            SITCP_RX_SIZE,
  input  logic                   SITCP_RX_CLR_ENB,
  output logic                   SITCP_RX_CLR_REQ,
  input  logic                   FLUSH,
  output logic                   RX_VALID,
  input  logic                   RX_READY,
  output logic [8*OUT_BYTES-1:0] RX_DATA,
  output logic [3:0]             RX_CNT,
  output logic [ADDR_W:0]        RX_AVAIL
);

  localparam int unsigned WORD_W = ADDR_W - 3;
  localparam int unsigned IDLE_W = (TAIL_TIMEOUT > 0) ? $clog2(TAIL_TIMEOUT + 1) : 1;

  if (!legal_width(ADDR_W, OUT_BYTES)) begin : g_bad_cfg
    $error("sitcpxg_rx_stream_buffer: illegal ADDR_W/OUT_BYTES");
  end

  rx_state_e         state, state_nx;
  logic [ADDR_W-1:0] wptr, wptr_nx, rptr, rptr_nx;
  logic [ADDR_W-1:0] avail, avail_nx, wr_end;
  logic [3:0]        cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              clr_armed, wr, go, tail_go;
  logic [7:0]        lane_q [8];
  logic [2:0]        lane_sel;
  logic              wadr_unused;

  assign wadr_unused = ^SITCP_RX_WADR;
  assign wr          = |SITCP_RX_WENB;
  assign wr_end      = {SITCP_RX_WADR[ADDR_W-1:3], 3'b000} + ADDR_W'(4'd8 - tz8(SITCP_RX_WENB));
  assign avail       = wptr - rptr;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    sitcpxg_lane_ram #(.DEPTH_W(WORD_W)) u_lane (
      .clk   (CLK),
      .we    (SITCP_RX_WENB[7-k]),
      .waddr (SITCP_RX_WADR[ADDR_W-1:3]),
      .wdata (SITCP_RX_WDAT[63-8*k -: 8]),
      .re    (state == ST_FETCH),
      .raddr (rptr[ADDR_W-1:3] + WORD_W'(3'(k) < rptr[2:0])),
      .rdata (lane_q[k])
    );
  end

  // The go condition is evaluated on post-update pointers so a word can be
  // fetched in the cycle right after the write or handshake that enables it.
  always_comb begin
    wptr_nx  = wr ? wr_end : wptr;
    rptr_nx  = rptr;
    state_nx = state;
    if (FLUSH)                                    rptr_nx = wptr;
    else if ((state == ST_PRESENT) && RX_READY)   rptr_nx = rptr + ADDR_W'(cnt);
    if (state == ST_CLEAR) begin
      wptr_nx = '0;
      rptr_nx = '0;
    end
    avail_nx = wptr_nx - rptr_nx;
    tail_go  = (TAIL_TIMEOUT != 0) && !wr && (idle_cnt == IDLE_W'(TAIL_TIMEOUT)) &&
               (avail_nx != '0);
    go       = (avail_nx >= ADDR_W'(OUT_BYTES)) || tail_go;
    unique case (state)
      ST_EMPTY: begin
        if (FLUSH)                                                        state_nx = ST_EMPTY;
        else if (go)                                                      state_nx = ST_FETCH;
        else if (SITCP_RX_CLR_ENB && clr_armed && (avail_nx == '0))       state_nx = ST_CLEAR;
      end
      ST_FETCH:   state_nx = FLUSH ? ST_EMPTY : ST_PRESENT;
      ST_PRESENT: begin
        if (FLUSH)         state_nx = ST_EMPTY;
        else if (RX_READY) state_nx = go ? ST_FETCH : ST_EMPTY;
      end
      ST_CLEAR:   state_nx = ST_EMPTY;
      default:    state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_EMPTY;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      idle_cnt  <= '0;
      clr_armed <= 1'b1;
      RX_AVAIL  <= '0;
    end else begin
      state    <= state_nx;
      wptr     <= wptr_nx;
      rptr     <= rptr_nx;
      RX_AVAIL <= {1'b0, avail_nx};
      if (state == ST_FETCH)
        cnt <= (avail >= ADDR_W'(OUT_BYTES)) ? 4'(OUT_BYTES) : avail[3:0];
      if (wr || (state == ST_CLEAR))             idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TAIL_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
      if (!SITCP_RX_CLR_ENB)           clr_armed <= 1'b1;
      else if (state_nx == ST_CLEAR)   clr_armed <= 1'b0;
    end
  end

  // Output byte i comes from lane (rptr[2:0] + i) mod 8; bytes past cnt read as zero.
  always_comb begin
    RX_DATA  = '0;
    lane_sel = '0;
    if (state == ST_PRESENT) begin
      for (int unsigned i = 0; i < OUT_BYTES; i++) begin
        lane_sel = 3'(i) + rptr[2:0];
        if (4'(i) < cnt) RX_DATA[8*(OUT_BYTES-1-i) +: 8] = lane_q[lane_sel];
      end
    end
  end

  assign RX_VALID         = (state == ST_PRESENT);
  assign RX_CNT           = (state == ST_PRESENT) ? cnt : 4'd0;
  assign SITCP_RX_CLR_REQ = (state == ST_CLEAR);
  assign SITCP_RX_RADR    = 16'(rptr);
  assign SITCP_RX_SIZE    = 16'((32'd1 << ADDR_W) - SITCP_RX_MARGIN);

endmodule

// File: tb/tb_sitcpxg_rx_stream_buffer.sv
// Directed self-checking bench: instance A (ADDR_W=12, 8-byte words), instance B (4-byte words).
module tb_sitcpxg_rx_stream_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_wadr, a_radr, a_size, b_wadr, b_radr, b_size;
  logic [7:0]  a_wenb, b_wenb;
  logic [63:0] a_wdat, b_wdat, a_data;
  logic [31:0] b_data;
  logic        a_clr_enb, a_clr_req, a_flush, a_valid, a_ready;
  logic        b_clr_enb, b_clr_req, b_flush, b_valid, b_ready;
  logic [3:0]  a_cnt, b_cnt;
  logic [12:0] a_avail;
  logic [16:0] b_avail;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sitcpxg_rx_stream_buffer #(.ADDR_W(12), .OUT_BYTES(8), .TAIL_TIMEOUT(64)) u_dut_a (
    .CLK(clk), .RST(rst), .SITCP_RX_WADR(a_wadr), .SITCP_RX_WENB(a_wenb),
    .SITCP_RX_WDAT(a_wdat), .SITCP_RX_RADR(a_radr), .SITCP_RX_SIZE(a_size),
    .SITCP_RX_CLR_ENB(a_clr_enb), .SITCP_RX_CLR_REQ(a_clr_req), .FLUSH(a_flush),
    .RX_VALID(a_valid), .RX_READY(a_ready), .RX_DATA(a_data), .RX_CNT(a_cnt),
    .RX_AVAIL(a_avail)
  );

  sitcpxg_rx_stream_buffer #(.ADDR_W(16), .OUT_BYTES(4), .TAIL_TIMEOUT(64)) u_dut_b (
    .CLK(clk), .RST(rst), .SITCP_RX_WADR(b_wadr), .SITCP_RX_WENB(b_wenb),
    .SITCP_RX_WDAT(b_wdat), .SITCP_RX_RADR(b_radr), .SITCP_RX_SIZE(b_size),
    .SITCP_RX_CLR_ENB(b_clr_enb), .SITCP_RX_CLR_REQ(b_clr_req), .FLUSH(b_flush),
    .RX_VALID(b_valid), .RX_READY(b_ready), .RX_DATA(b_data), .RX_CNT(b_cnt),
    .RX_AVAIL(b_avail)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_write(input logic [15:0] adr, input logic [7:0] enb, input logic [63:0] dat);
    a_wadr = adr; a_wenb = enb; a_wdat = dat;
    tick();
    a_wenb = 8'h00;
  endtask

  task automatic b_write(input logic [15:0] adr, input logic [7:0] enb, input logic [63:0] dat);
    b_wadr = adr; b_wenb = enb; b_wdat = dat;
    tick();
    b_wenb = 8'h00;
  endtask

  task automatic wait_a(input string tag, input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && !a_valid; i++) tick();
    check_val({tag, "_valid"}, 64'(a_valid), 64'd1);
  endtask

  task automatic wait_b(input string tag, input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && !b_valid; i++) tick();
    check_val({tag, "_valid"}, 64'(b_valid), 64'd1);
  endtask

  logic [31:0] b_exp [3];
  int unsigned seen, pulses;
  logic        stable;

  initial begin
    rst = 1'b1;
    a_wadr = '0; a_wenb = '0; a_wdat = '0; a_clr_enb = 1'b0; a_flush = 1'b0; a_ready = 1'b1;
    b_wadr = '0; b_wenb = '0; b_wdat = '0; b_clr_enb = 1'b0; b_flush = 1'b0; b_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check_val("rst_valid", 64'(a_valid), 64'd0);
    check_val("rst_cnt", 64'(a_cnt), 64'd0);
    check_val("rst_data", a_data, 64'd0);
    check_val("rst_radr", 64'(a_radr), 64'd0);
    check_val("rst_avail", 64'(a_avail), 64'd0);
    check_val("rst_clr_req", 64'(a_clr_req), 64'd0);
    check_val("size_a", 64'(a_size), 64'h0FF0);
    check_val("size_b", 64'(b_size), 64'hFFF0);

    // Single aligned word: valid two cycles after the write
    a_write(16'h0000, 8'hFF, 64'h0011223344556677);
    check_val("w1_early", 64'(a_valid), 64'd0);
    check_val("w1_avail", 64'(a_avail), 64'd8);
    tick();
    check_val("w1_valid", 64'(a_valid), 64'd1);
    check_val("w1_data", a_data, 64'h0011223344556677);
    check_val("w1_cnt", 64'(a_cnt), 64'd8);
    tick();
    check_val("w1_radr", 64'(a_radr), 64'h0008);
    check_val("w1_done", 64'(a_valid), 64'd0);

    // Four-byte words on instance B
    b_exp[0] = 32'h00010203; b_exp[1] = 32'h04050607; b_exp[2] = 32'h08090A0B;
    b_write(16'h0000, 8'hFF, 64'h0001020304050607);
    b_write(16'h0008, 8'hF0, 64'h08090A0BDEADBEEF);
    for (int unsigned w = 0; w < 3; w++) begin
      wait_b("b4", 8);
      check_val("b4_data", 64'(b_data), 64'(b_exp[w]));
      check_val("b4_cnt", 64'(b_cnt), 64'd4);
      tick();
    end
    check_val("b4_radr", 64'(b_radr), 64'h000C);

    // Partial tail after the idle timeout
    a_write(16'h0008, 8'hE0, 64'hAABBCC0000000000);
    seen = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (a_valid) seen++;
      tick();
    end
    check_val("tail_quiet", 64'(seen), 64'd0);
    wait_a("tail", 8);
    check_val("tail_data", a_data, 64'hAABBCC0000000000);
    check_val("tail_cnt", 64'(a_cnt), 64'd3);
    tick();
    check_val("tail_radr", 64'(a_radr), 64'h000B);

    // Unaligned word starting at offset 3
    a_write(16'h0008, 8'h1F, 64'h0000001122334455);
    a_write(16'h0010, 8'hE0, 64'h6677880000000000);
    wait_a("unal", 8);
    check_val("unal_data", a_data, 64'h1122334455667788);
    check_val("unal_cnt", 64'(a_cnt), 64'd8);
    tick();
    check_val("unal_radr", 64'(a_radr), 64'h0013);

    // Backpressure: stalled word holds while writes continue
    a_ready = 1'b0;
    a_write(16'h0010, 8'h1F, 64'h000000C0C1C2C3C4);
    a_write(16'h0018, 8'hFF, 64'hC5C6C7C8C9CACBCC);
    wait_a("bp", 8);
    check_val("bp_data", a_data, 64'hC0C1C2C3C4C5C6C7);
    stable = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (i == 0) a_write(16'h0020, 8'hFF, 64'hD0D1D2D3D4D5D6D7);
      else        tick();
      if (!a_valid || a_data != 64'hC0C1C2C3C4C5C6C7 || a_cnt != 4'd8 || a_radr != 16'h0013)
        stable = 1'b0;
    end
    check_val("bp_stable", 64'(stable), 64'd1);
    check_val("bp_avail", 64'(a_avail), 64'd21);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check_val("bp_radr", 64'(a_radr), 64'h001B);
    a_write(16'h0028, 8'hFF, 64'hE0E1E2E3E4E5E6E7);
    wait_a("bp2", 8);
    check_val("bp2_data", a_data, 64'hC8C9CACBCCD0D1D2);

    // Clear refused while bytes pending; flush then a single clear pulse
    a_clr_enb = 1'b1;
    pulses = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (a_clr_req) pulses++;
    end
    check_val("clr_blocked", 64'(pulses), 64'd0);
    check_val("clr_avail", 64'(a_avail), 64'd21);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check_val("flush_valid", 64'(a_valid), 64'd0);
    check_val("flush_avail", 64'(a_avail), 64'd0);
    pulses = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      if (a_clr_req) pulses++;
    end
    check_val("clr_pulses", 64'(pulses), 64'd1);
    check_val("clr_radr", 64'(a_radr), 64'h0000);
    a_clr_enb = 1'b0;
    tick();

    // Wrap across the top of a 4 KiB buffer
    a_write(16'h0FF8, 8'hF0, 64'h0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check_val("wrap_rptr", 64'(a_radr), 64'h0FFC);
    a_ready = 1'b1;
    a_write(16'h0FF8, 8'h0F, 64'hDEADBEEFA0A1A2A3);
    a_write(16'h0000, 8'hF0, 64'hA4A5A6A7DEADBEEF);
    wait_a("wrap", 8);
    check_val("wrap_data", a_data, 64'hA0A1A2A3A4A5A6A7);
    check_val("wrap_cnt", 64'(a_cnt), 64'd8);
    tick();
    check_val("wrap_radr", 64'(a_radr), 64'h0004);

    // Asynchronous reset while a word is presented
    a_ready = 1'b0;
    a_write(16'h0008, 8'hFF, 64'h0123456789ABCDEF);
    wait_a("arst", 8);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(a_valid), 64'd0);
    check_val("arst_radr", 64'(a_radr), 64'h0000);
    check_val("arst_avail", 64'(a_avail), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
